dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter WORD_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 9, word address width; 16-word blocks, 8 lines, 2-bit tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_valid  input  1  CPU request present.
REQ-006 cpu_ready  output  1  controller accepts a request this cycle.
REQ-007 cpu_we  input  1  1 = write, 0 = read.
REQ-008 cpu_addr  input  9  word address: tag [8:7], index [6:4], offset [3:0].
REQ-009 cpu_wdata  input  32  write data.
REQ-010 resp_valid  output  1  one-cycle pulse when the request completes.
REQ-011 resp_rdata  output  32  read data, valid with resp_valid; write responses return the written word.
REQ-012 madd  output  9  block address to memory, {tag,index,4'b0}.
REQ-013 mem_we  output  1  memory block write strobe.
REQ-014 mem_re  output  1  memory block read strobe.
REQ-015 mem_din  output  512  block to memory; word i on bits [i*32 +: 32].
REQ-016 mem_dout  input  512  block from memory; combinational response to madd/mem_re.
REQ-017 hit_cnt, miss_cnt  output  16 each  saturating event counters.

Function
REQ-018 Direct-mapped, write-back, write-allocate; 8 lines x 16 words, per-line valid, dirty, 2-bit tag.
REQ-019 FSM states: IDLE, LOOKUP, WB, FILL.
REQ-020 IDLE: cpu_ready=1; on cpu_valid latch we/addr/wdata, go to LOOKUP; no other state asserts cpu_ready.
REQ-021 LOOKUP hit (valid and tag match): read returns word[offset]; write updates word[offset] and sets dirty; resp_valid pulses the next cycle; go to IDLE; hit_cnt increments.
REQ-022 LOOKUP miss: miss_cnt increments once per request; to WB if victim valid and dirty, else to FILL.
REQ-023 WB: exactly one cycle, mem_we=1, madd={victim tag,index,0}, mem_din=victim line; clear dirty; go to FILL.
REQ-024 FILL: exactly one cycle, mem_re=1, madd={req tag,index,0}; capture mem_dout into the line; set valid, set tag, clear dirty; go to LOOKUP, which then hits without incrementing hit_cnt.
REQ-025 mem_we and mem_re are never asserted together, and are 0 outside WB/FILL.
REQ-026 Latency from acceptance edge to resp_valid: hit 2 cycles; clean miss 4; dirty miss 5.
REQ-027 A new request may be accepted in the same cycle resp_valid is high.
REQ-028 Counters saturate at 16'hFFFF and do not wrap.
REQ-029 A request that changes cpu_* after acceptance has no effect; only latched values are used.

Reset
REQ-030 rst_n low asynchronously: FSM to IDLE; all valid and dirty bits 0; hit_cnt, miss_cnt, resp_valid, mem_we, mem_re 0; resp_rdata 0.
REQ-031 Reset mid-WB or mid-FILL abandons the transfer; data arrays need not be cleared.
REQ-032 cpu_ready is 1 on the first cycle after rst_n deasserts.

Structure
REQ-033 Package dcache_pkg holds the state enum, field widths (TAG_W=2, IDX_W=3, OFF_W=4), LINES=8, and BLOCK_W=512.
REQ-034 One sub-module dcache_array (data, tag, valid and dirty storage, with line read/write and word write) is instantiated once.

Verification
Memory preload for all scenarios: word 16 = FFFFFFFF, words 17-32 = 00000001, words 33-48 = 7FFFFFFF, other word i = FFFFFFF0 + (i mod 16).
REQ-035 Reset, then read 0x011 -> clean miss: mem_re pulses with madd=0x010, resp_rdata=00000001 at 4 cycles, miss_cnt=1.
REQ-036 Then read 0x012 -> hit: resp_rdata=00000001 at 2 cycles, hit_cnt=1, no memory strobe.
REQ-037 Then write DEADBEEF to 0x011, then read 0x091 -> dirty miss: mem_we with madd=0x010 and mem_din word1=DEADBEEF, then mem_re madd=0x090, resp_rdata=FFFFFFF1 at 5 cycles.
REQ-038 Then read 0x011 -> miss, memory returns DEADBEEF.
REQ-039 Assert rst_n low during FILL -> outputs to reset values immediately; a subsequent read of 0x011 misses.
REQ-040 Force hit_cnt near FFFF with repeated hits -> holds at FFFF.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
// Holds the address field widths, line geometry, counter width and FSM state type.
package dcache_pkg;

    localparam int unsigned TAG_W   = 2;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned LINES   = 1 << IDX_W;
    localparam int unsigned WORDS   = 1 << OFF_W;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StWb,
        StFill
    } state_e;

endpackage

// File: rtl/dcache_array.sv
// Storage for the cache: per-line data block, tag, valid and dirty bits.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset (valid/dirty only)
//   idx_i               line index used for both read and write
//   line_o/tag_o/valid_o/dirty_o  combinational read of the indexed line
//   fill_i              write whole block + tag, set valid, clear dirty
//   fill_tag_i/fill_line_i        block contents for a fill
//   word_we_i/off_i/wdata_i       single-word write, marks the line dirty
//   clr_dirty_i         clear dirty bit (after write-back)
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned WordW = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IDX_W-1:0]       idx_i,
    output logic [WORDS*WordW-1:0] line_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic                   valid_o,
    output logic                   dirty_o,
    input  logic                   fill_i,
    input  logic [TAG_W-1:0]       fill_tag_i,
    input  logic [WORDS*WordW-1:0] fill_line_i,
    input  logic                   word_we_i,
    input  logic [OFF_W-1:0]       off_i,
    input  logic [WordW-1:0]       wdata_i,
    input  logic                   clr_dirty_i
);

    logic [WORDS*WordW-1:0] data_q [LINES];
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;

    assign line_o  = data_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    // Data and tags are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            data_q[idx_i] <= fill_line_i;
            tag_q[idx_i]  <= fill_tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][off_i*WordW +: WordW] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 8 lines x 16 words; one request in flight; whole-block memory transfers.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_valid/cpu_ready             request handshake (ready only in idle)
//   cpu_we/cpu_addr/cpu_wdata       request, latched on acceptance
//   resp_valid/resp_rdata           one-cycle completion pulse and data
//   madd/mem_we/mem_re/mem_din      block address, write/read strobes, write block
//   mem_dout                        block returned combinationally by memory
//   hit_cnt/miss_cnt                saturating event counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [WORD_W-1:0]       cpu_wdata,
    output logic                    resp_valid,
    output logic [WORD_W-1:0]       resp_rdata,
    output logic [ADDR_W-1:0]       madd,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [WORDS*WORD_W-1:0] mem_din,
    input  logic [WORDS*WORD_W-1:0] mem_dout,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);

    state_e state_q, state_d;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [WORD_W-1:0] req_wdata_q;
    // Set by a fill so the lookup that follows it is not counted as a hit.
    logic              refill_q;
    logic              resp_valid_q;
    logic [WORD_W-1:0] resp_rdata_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;

    logic [WORDS*WORD_W-1:0] arr_line;
    logic [TAG_W-1:0]        arr_tag;
    logic                    arr_valid;
    logic                    arr_dirty;
    logic                    arr_fill;
    logic                    arr_word_we;
    logic                    arr_clr_dirty;

    logic              hit;
    logic              accept;
    logic              lookup_hit;
    logic              lookup_miss;
    logic [WORD_W-1:0] cur_word;

    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr_q[OFF_W +: IDX_W];
    assign req_off = req_addr_q[OFF_W-1:0];

    assign hit         = arr_valid && (arr_tag == req_tag);
    assign accept      = (state_q == StIdle) && cpu_valid;
    assign lookup_hit  = (state_q == StLookup) && hit;
    assign lookup_miss = (state_q == StLookup) && !hit;
    assign cur_word    = arr_line[req_off*WORD_W +: WORD_W];

    dcache_array #(
        .WordW (WORD_W)
    ) u_array (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .idx_i       (req_idx),
        .line_o      (arr_line),
        .tag_o       (arr_tag),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .fill_i      (arr_fill),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_dout),
        .word_we_i   (arr_word_we),
        .off_i       (req_off),
        .wdata_i     (req_wdata_q),
        .clr_dirty_i (arr_clr_dirty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_valid) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    state_d = StIdle;
                end else if (arr_valid && arr_dirty) begin
                    state_d = StWb;
                end else begin
                    state_d = StFill;
                end
            end
            StWb:    state_d = StFill;
            StFill:  state_d = StLookup;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs and array controls.
    always_comb begin
        cpu_ready     = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        madd          = {req_tag, req_idx, {OFF_W{1'b0}}};
        arr_fill      = 1'b0;
        arr_word_we   = 1'b0;
        arr_clr_dirty = 1'b0;
        unique case (state_q)
            StIdle:   cpu_ready   = 1'b1;
            StLookup: arr_word_we = hit && req_we_q;
            StWb: begin
                mem_we        = 1'b1;
                madd          = {arr_tag, req_idx, {OFF_W{1'b0}}};
                arr_clr_dirty = 1'b1;
            end
            StFill: begin
                mem_re   = 1'b1;
                arr_fill = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch, response and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            refill_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (accept) begin
                req_we_q    <= cpu_we;
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
                refill_q    <= 1'b0;
            end
            if (state_q == StFill) refill_q <= 1'b1;
            resp_valid_q <= lookup_hit;
            if (lookup_hit) resp_rdata_q <= req_we_q ? req_wdata_q : cur_word;
            if (lookup_hit && !refill_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (lookup_miss && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign mem_din    = arr_line;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset-during-fill
// sequence, randomized traffic against a line-level cache model, counter saturation.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_valid;
    logic         cpu_ready;
    logic         cpu_we;
    logic [8:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic [8:0]   madd;
    logic         mem_we;
    logic         mem_re;
    logic [511:0] mem_din;
    logic [511:0] mem_dout;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .madd       (madd),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    function automatic logic [31:0] preload(input int i);
        if (i == 16) return 32'hFFFF_FFFF;
        if (i >= 17 && i <= 32) return 32'h0000_0001;
        if (i >= 33 && i <= 48) return 32'h7FFF_FFFF;
        return 32'hFFFF_FFF0 + 32'(i % 16);
    endfunction

    // Backing memory seen by the DUT.
    logic [31:0] mem [512];
    bit          loaded = 1'b0;

    always_comb begin
        mem_dout = '0;
        for (int w = 0; w < 16; w++) mem_dout[w*32 +: 32] = mem[int'(madd) + w];
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= preload(i);
            loaded <= 1'b1;
        end else if (mem_we) begin
            for (int w = 0; w < 16; w++) mem[int'(madd) + w] <= mem_din[w*32 +: 32];
        end
    end

    typedef struct {
        logic [31:0]  rdata;
        int           lat;
        int           n_wb;
        logic [8:0]   wb_addr;
        logic [511:0] wb_blk;
        int           n_fill;
        logic [8:0]   fill_addr;
        logic [15:0]  hc;
        logic [15:0]  mc;
        int           both;
    } obs_t;

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [31:0] wd;
        obs_t       exp;
    } vec_t;

    // Reference model: whole-line view of the cache plus its own memory image.
    logic [31:0] ref_mem [512];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [1:0]  m_tag   [8];
    logic [31:0] m_data  [8][16];
    int          m_hits;
    int          m_misses;

    task automatic model_reset();
        for (int l = 0; l < 8; l++) begin
            m_valid[l] = 1'b0;
            m_dirty[l] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                             output obs_t e);
        int idx = int'(addr[6:4]);
        int off = int'(addr[3:0]);
        e = '{rdata: '0, lat: 2, n_wb: 0, wb_addr: '0, wb_blk: '0, n_fill: 0,
              fill_addr: '0, hc: '0, mc: '0, both: 0};
        if (m_valid[idx] && m_tag[idx] == addr[8:7]) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
            e.lat = 4;
            if (m_valid[idx] && m_dirty[idx]) begin
                e.lat     = 5;
                e.n_wb    = 1;
                e.wb_addr = {m_tag[idx], addr[6:4], 4'b0};
                for (int w = 0; w < 16; w++) begin
                    e.wb_blk[w*32 +: 32] = m_data[idx][w];
                    ref_mem[int'(e.wb_addr) + w] = m_data[idx][w];
                end
            end
            e.n_fill    = 1;
            e.fill_addr = {addr[8:7], addr[6:4], 4'b0};
            for (int w = 0; w < 16; w++) m_data[idx][w] = ref_mem[int'(e.fill_addr) + w];
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = addr[8:7];
        end
        if (we) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
            e.rdata          = wd;
        end else begin
            e.rdata = m_data[idx][off];
        end
        e.hc = 16'(m_hits);
        e.mc = 16'(m_misses);
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request at the current negedge; watch until resp_valid or timeout.
    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                          output obs_t o);
        o = '{rdata: '0, lat: -1, n_wb: 0, wb_addr: '0, wb_blk: '0, n_fill: 0,
              fill_addr: '0, hc: '0, mc: '0, both: 0};
        chk("ready_before_req", {511'b0, cpu_ready}, 512'd1);
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the bus: only latched values may be used.
        cpu_valid = 1'b0;
        cpu_we    = ~we;
        cpu_addr  = 9'($urandom);
        cpu_wdata = $urandom;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_we && mem_re) o.both++;
            if (mem_we) begin
                o.n_wb++;
                o.wb_addr = madd;
                o.wb_blk  = mem_din;
            end
            if (mem_re) begin
                o.n_fill++;
                o.fill_addr = madd;
            end
            if (resp_valid) begin
                o.lat   = c;
                o.rdata = resp_rdata;
                o.hc    = hit_cnt;
                o.mc    = miss_cnt;
                break;
            end
        end
    endtask

    task automatic cmp_obs(input string t, input obs_t o, input obs_t e, input bit full_blk);
        chk({t, "_rdata"}, 512'(o.rdata), 512'(e.rdata));
        chk({t, "_latency"}, 512'(o.lat), 512'(e.lat));
        chk({t, "_wb_count"}, 512'(o.n_wb), 512'(e.n_wb));
        chk({t, "_fill_count"}, 512'(o.n_fill), 512'(e.n_fill));
        chk({t, "_we_re_overlap"}, 512'(o.both), 512'(e.both));
        chk({t, "_hit_cnt"}, 512'(o.hc), 512'(e.hc));
        chk({t, "_miss_cnt"}, 512'(o.mc), 512'(e.mc));
        if (e.n_wb != 0) begin
            chk({t, "_wb_addr"}, 512'(o.wb_addr), 512'(e.wb_addr));
            if (full_blk) chk({t, "_wb_block"}, o.wb_blk, e.wb_blk);
            else chk({t, "_wb_word1"}, 512'(o.wb_blk[63:32]), 512'(e.wb_blk[63:32]));
        end
        if (e.n_fill != 0) chk({t, "_fill_addr"}, 512'(o.fill_addr), 512'(e.fill_addr));
    endtask

    function automatic vec_t mkv(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int lat, input int n_wb,
                                 input logic [8:0] wb_addr, input logic [31:0] wb_w1,
                                 input int n_fill, input logic [8:0] fill_addr,
                                 input logic [15:0] hc, input logic [15:0] mc);
        vec_t v;
        v.we = we;
        v.addr = addr;
        v.wd = wd;
        v.exp = '{rdata: rd, lat: lat, n_wb: n_wb, wb_addr: wb_addr, wb_blk: '0,
                  n_fill: n_fill, fill_addr: fill_addr, hc: hc, mc: mc, both: 0};
        v.exp.wb_blk[63:32] = wb_w1;
        return v;
    endfunction

    // Directed vector: keep the model in step, compare the DUT against table values.
    task automatic run_vec(input string t, input vec_t v);
        obs_t e, o;
        model_req(v.we, v.addr, v.wd, e);
        do_req(v.we, v.addr, v.wd, o);
        cmp_obs(t, o, v.exp, 1'b0);
    endtask

    task automatic run_model(input string t, input logic we, input logic [8:0] addr,
                             input logic [31:0] wd);
        obs_t e, o;
        model_req(we, addr, wd, e);
        do_req(we, addr, wd, o);
        cmp_obs(t, o, e, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string t);
        chk({t, "_cpu_ready"}, 512'(cpu_ready), 512'd1);
        chk({t, "_resp_valid"}, 512'(resp_valid), 512'd0);
        chk({t, "_resp_rdata"}, 512'(resp_rdata), 512'd0);
        chk({t, "_mem_we"}, 512'(mem_we), 512'd0);
        chk({t, "_mem_re"}, 512'(mem_re), 512'd0);
        chk({t, "_hit_cnt"}, 512'(hit_cnt), 512'd0);
        chk({t, "_miss_cnt"}, 512'(miss_cnt), 512'd0);
    endtask

    vec_t vecs [5];

    initial begin
        bit seen;
        for (int i = 0; i < 512; i++) ref_mem[i] = preload(i);
        model_reset();

        vecs[0] = mkv(0, 9'h011, 32'h0,         32'h0000_0001, 4, 0, 9'h0,   32'h0,
                      1, 9'h010, 16'd0, 16'd1);
        vecs[1] = mkv(0, 9'h012, 32'h0,         32'h0000_0001, 2, 0, 9'h0,   32'h0,
                      0, 9'h0,   16'd1, 16'd1);
        vecs[2] = mkv(1, 9'h011, 32'hDEADBEEF,  32'hDEADBEEF,  2, 0, 9'h0,   32'h0,
                      0, 9'h0,   16'd2, 16'd1);
        vecs[3] = mkv(0, 9'h091, 32'h0,         32'hFFFF_FFF1, 5, 1, 9'h010, 32'hDEADBEEF,
                      1, 9'h090, 16'd2, 16'd2);
        vecs[4] = mkv(0, 9'h011, 32'h0,         32'hDEADBEEF,  4, 0, 9'h0,   32'h0,
                      1, 9'h010, 16'd2, 16'd3);

        rst_n     = 1'b0;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 512'(cpu_ready), 512'd1);
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset while a clean-miss fill is on the memory bus.
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 9'h191;
        cpu_wdata = '0;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (mem_re) seen = 1'b1;
        end
        chk("fill_strobe_seen", 512'(seen), 512'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_in_fill");
        rst_n = 1'b1;
        #1;
        chk("ready_after_fill_reset", 512'(cpu_ready), 512'd1);
        @(negedge clk);
        model_reset();
        run_vec("post_reset", mkv(0, 9'h011, 32'h0, 32'hDEADBEEF, 4, 0, 9'h0, 32'h0,
                                  1, 9'h010, 16'd0, 16'd1));

        // Random traffic over a few indices so hits, clean and dirty misses all occur.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] tg;
            logic [2:0] ix;
            logic [3:0] of;
            tg = 2'($urandom_range(0, 3));
            ix = 3'($urandom_range(0, 2));
            of = 4'($urandom_range(0, 15));
            run_model($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), {tg, ix, of}, $urandom);
        end

        // Counter saturation: preset near the top, then keep hitting one line.
        run_model("sat_load", 1'b0, 9'h013, 32'h0);
        force dut.hit_cnt_q = 16'hFFFC;
        #1;
        release dut.hit_cnt_q;
        m_hits = 16'hFFFC;
        for (int k = 0; k < 6; k++) run_model($sformatf("sat%0d", k), 1'b0, 9'h013, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
